// File: rtl/id_ex_alu_issue_pkg.sv
// Shared ALU op codes, MIPS opcode/funct constants and the ID/EX bundle.
// Consumed by the issue stage and the ALU.
package id_ex_alu_issue_pkg;

    localparam logic [5:0] ALU_NOP  = 6'h00;
    localparam logic [5:0] ALU_ADDU = 6'h01;
    localparam logic [5:0] ALU_SUBU = 6'h02;
    localparam logic [5:0] ALU_ADD  = 6'h03;
    localparam logic [5:0] ALU_AND  = 6'h04;
    localparam logic [5:0] ALU_OR   = 6'h05;
    localparam logic [5:0] ALU_SLT  = 6'h06;
    localparam logic [5:0] ALU_LUI  = 6'h07;
    localparam logic [5:0] ALU_SLL  = 6'h08;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_SEXT = 2'd1,
        IMM_ZEXT = 2'd2
    } imm_sel_e;

    typedef struct packed {
        logic        valid;
        logic [5:0]  alu_ctrl;
        logic [4:0]  sa;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] store_data;
        logic [4:0]  dst;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        branch;
        logic        illegal;
    } id_ex_t;

endpackage

// File: rtl/id_ex_alu_issue_decode.sv
// Combinational MIPS decoder: opcode/funct to ALU op, operand selects
// and pipeline controls.
module alu_issue_decode
    import id_ex_alu_issue_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic [4:0] shamt,
    output logic [5:0] alu_ctrl,
    output logic [4:0] sa,
    output logic [1:0] imm_sel,
    output logic       dst_rd,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       branch,
    output logic       illegal,
    output logic       uses_rt
);

    // Decode one instruction; anything unmatched is flagged illegal.
    always_comb begin
        alu_ctrl   = ALU_NOP;
        sa         = 5'd0;
        imm_sel    = IMM_NONE;
        dst_rd     = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        branch     = 1'b0;
        illegal    = 1'b0;
        uses_rt    = 1'b0;
        unique case (1'b1)
            (op == OP_RTYPE): begin
                dst_rd    = 1'b1;
                reg_write = 1'b1;
                uses_rt   = 1'b1;
                unique case (1'b1)
                    (funct == FN_ADD):  alu_ctrl = ALU_ADD;
                    (funct == FN_ADDU): alu_ctrl = ALU_ADDU;
                    (funct == FN_SUBU): alu_ctrl = ALU_SUBU;
                    (funct == FN_AND):  alu_ctrl = ALU_AND;
                    (funct == FN_OR):   alu_ctrl = ALU_OR;
                    (funct == FN_SLT):  alu_ctrl = ALU_SLT;
                    (funct == FN_SLL): begin
                        alu_ctrl = ALU_SLL;
                        sa       = shamt;
                    end
                    default: begin
                        dst_rd    = 1'b0;
                        reg_write = 1'b0;
                        uses_rt   = 1'b0;
                        illegal   = 1'b1;
                    end
                endcase
            end
            (op == OP_ADDIU): begin
                alu_ctrl  = ALU_ADDU;
                imm_sel   = IMM_SEXT;
                reg_write = 1'b1;
            end
            (op == OP_ORI): begin
                alu_ctrl  = ALU_OR;
                imm_sel   = IMM_ZEXT;
                reg_write = 1'b1;
            end
            (op == OP_LUI): begin
                alu_ctrl  = ALU_LUI;
                imm_sel   = IMM_ZEXT;
                reg_write = 1'b1;
            end
            (op == OP_LW): begin
                alu_ctrl   = ALU_ADDU;
                imm_sel    = IMM_SEXT;
                reg_write  = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
            end
            (op == OP_SW): begin
                alu_ctrl  = ALU_ADDU;
                imm_sel   = IMM_SEXT;
                mem_write = 1'b1;
                uses_rt   = 1'b1;
            end
            (op == OP_BEQ): begin
                alu_ctrl = ALU_SUBU;
                branch   = 1'b1;
                uses_rt  = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline register feeding the ALU, with load-use bubble
// insertion, downstream hold and branch flush.
module id_ex_alu_issue
    import id_ex_alu_issue_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [31:0]   id_instr,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic          ex_hold,
    input  logic          flush,
    output logic          id_stall,
    output logic          ex_valid,
    output logic [5:0]    ex_alu_ctrl,
    output logic [4:0]    ex_sa,
    output logic [DW-1:0] ex_a,
    output logic [DW-1:0] ex_b,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_dst,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_mem_to_reg,
    output logic          ex_branch,
    output logic          ex_illegal
);

    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic [15:0]   imm;
    logic [5:0]    d_alu_ctrl;
    logic [4:0]    d_sa;
    logic [1:0]    d_imm_sel;
    logic          d_dst_rd;
    logic          d_reg_write;
    logic          d_mem_read;
    logic          d_mem_write;
    logic          d_mem_to_reg;
    logic          d_branch;
    logic          d_illegal;
    logic          d_uses_rt;
    logic          hazard;
    id_ex_t        r;
    id_ex_t        nxt;

    assign rs  = id_instr[25:21];
    assign rt  = id_instr[20:16];
    assign rd  = id_instr[15:11];
    assign imm = id_instr[15:0];

    alu_issue_decode u_dec (
        .op         (id_instr[31:26]),
        .funct      (id_instr[5:0]),
        .shamt      (id_instr[10:6]),
        .alu_ctrl   (d_alu_ctrl),
        .sa         (d_sa),
        .imm_sel    (d_imm_sel),
        .dst_rd     (d_dst_rd),
        .reg_write  (d_reg_write),
        .mem_read   (d_mem_read),
        .mem_write  (d_mem_write),
        .mem_to_reg (d_mem_to_reg),
        .branch     (d_branch),
        .illegal    (d_illegal),
        .uses_rt    (d_uses_rt)
    );

    // A load in EX whose result the ID instruction needs costs one bubble.
    always_comb begin
        hazard = r.valid && r.mem_read && (r.dst != '0) && id_valid
              && ((r.dst == rs) || (d_uses_rt && (r.dst == rt)));
        id_stall = !rst && !flush && (ex_hold || hazard);
    end

    // Assemble the bundle the ID instruction would occupy in EX.
    always_comb begin
        nxt            = '0;
        nxt.valid      = 1'b1;
        nxt.alu_ctrl   = d_alu_ctrl;
        nxt.sa         = d_sa;
        nxt.a          = id_rs_data;
        nxt.store_data = id_rt_data;
        nxt.reg_write  = d_reg_write;
        nxt.mem_read   = d_mem_read;
        nxt.mem_write  = d_mem_write;
        nxt.mem_to_reg = d_mem_to_reg;
        nxt.branch     = d_branch;
        nxt.illegal    = d_illegal;
        nxt.dst        = d_illegal ? '0 : (d_dst_rd ? rd : rt);
        unique case (1'b1)
            (d_imm_sel == IMM_SEXT): nxt.b = {{16{imm[15]}}, imm};
            (d_imm_sel == IMM_ZEXT): nxt.b = {16'h0, imm};
            default:                 nxt.b = id_rt_data;
        endcase
    end

    // Priority: reset, flush, hold, bubble (hazard or empty ID), load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
        end else if (flush) begin
            r <= '0;
        end else if (ex_hold) begin
            r <= r;
        end else if (hazard || !id_valid) begin
            r <= '0;
        end else begin
            r <= nxt;
        end
    end

    assign ex_valid      = r.valid;
    assign ex_alu_ctrl   = r.alu_ctrl;
    assign ex_sa         = r.sa;
    assign ex_a          = r.a;
    assign ex_b          = r.b;
    assign ex_store_data = r.store_data;
    assign ex_dst        = r.dst;
    assign ex_reg_write  = r.reg_write;
    assign ex_mem_read   = r.mem_read;
    assign ex_mem_write  = r.mem_write;
    assign ex_mem_to_reg = r.mem_to_reg;
    assign ex_branch     = r.branch;
    assign ex_illegal    = r.illegal;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed self-checking bench for id_ex_alu_issue.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_id_ex_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic        ex_hold;
    logic        flush;
    logic        id_stall;
    logic        ex_valid;
    logic [5:0]  ex_alu_ctrl;
    logic [4:0]  ex_sa;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_dst;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_mem_to_reg;
    logic        ex_branch;
    logic        ex_illegal;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_alu_issue dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_rs_data    (id_rs_data),
        .id_rt_data    (id_rt_data),
        .ex_hold       (ex_hold),
        .flush         (flush),
        .id_stall      (id_stall),
        .ex_valid      (ex_valid),
        .ex_alu_ctrl   (ex_alu_ctrl),
        .ex_sa         (ex_sa),
        .ex_a          (ex_a),
        .ex_b          (ex_b),
        .ex_store_data (ex_store_data),
        .ex_dst        (ex_dst),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_branch     (ex_branch),
        .ex_illegal    (ex_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic [31:0] rsd, input logic [31:0] rtd);
        id_valid   = v;
        id_instr   = ins;
        id_rs_data = rsd;
        id_rt_data = rtd;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".valid"}, {31'd0, ex_valid}, 32'd0);
        chk({tag, ".ctrl"}, {26'd0, ex_alu_ctrl}, 32'd0);
        chk({tag, ".a"}, ex_a, 32'd0);
        chk({tag, ".b"}, ex_b, 32'd0);
        chk({tag, ".st"}, ex_store_data, 32'd0);
        chk({tag, ".dst"}, {27'd0, ex_dst}, 32'd0);
        chk({tag, ".en"}, {26'd0, ex_reg_write, ex_mem_read, ex_mem_write,
                           ex_mem_to_reg, ex_branch, ex_illegal}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        ex_hold = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        chk_bubble("reset");
        chk("reset.stall", {31'd0, id_stall}, 32'd0);

        rst = 1'b0;
        drive(1'b1, 32'h00221821, 32'd5, 32'd7);
        tick();
        chk("addu.ctrl", {26'd0, ex_alu_ctrl}, 32'h01);
        chk("addu.a", ex_a, 32'd5);
        chk("addu.b", ex_b, 32'd7);
        chk("addu.dst", {27'd0, ex_dst}, 32'd3);
        chk("addu.rw", {31'd0, ex_reg_write}, 32'd1);
        chk("addu.valid", {31'd0, ex_valid}, 32'd1);

        drive(1'b1, 32'h2404FFFF, 32'd0, 32'h55);
        tick();
        chk("addiu.b", ex_b, 32'hFFFFFFFF);
        chk("addiu.ctrl", {26'd0, ex_alu_ctrl}, 32'h01);
        chk("addiu.dst", {27'd0, ex_dst}, 32'd4);

        drive(1'b1, 32'h3404FFFF, 32'd0, 32'h55);
        tick();
        chk("ori.b", ex_b, 32'h0000FFFF);
        chk("ori.ctrl", {26'd0, ex_alu_ctrl}, 32'h05);

        drive(1'b1, 32'h3C041234, 32'd0, 32'h55);
        tick();
        chk("lui.ctrl", {26'd0, ex_alu_ctrl}, 32'h07);
        chk("lui.b", ex_b, 32'h00001234);

        drive(1'b1, 32'h000410C0, 32'd0, 32'd9);
        tick();
        chk("sll.ctrl", {26'd0, ex_alu_ctrl}, 32'h08);
        chk("sll.sa", {27'd0, ex_sa}, 32'd3);
        chk("sll.dst", {27'd0, ex_dst}, 32'd2);

        drive(1'b1, 32'h8C220000, 32'h40, 32'd0);
        tick();
        chk("lw.mr", {31'd0, ex_mem_read}, 32'd1);
        chk("lw.m2r", {31'd0, ex_mem_to_reg}, 32'd1);
        chk("lw.dst", {27'd0, ex_dst}, 32'd2);
        drive(1'b1, 32'h00421820, 32'd11, 32'd11);
        #1;
        chk("lu.stall", {31'd0, id_stall}, 32'd1);
        tick();
        chk_bubble("lu.bubble");
        chk("lu.stall_clr", {31'd0, id_stall}, 32'd0);
        tick();
        chk("lu.add.ctrl", {26'd0, ex_alu_ctrl}, 32'h03);
        chk("lu.add.valid", {31'd0, ex_valid}, 32'd1);
        chk("lu.add.dst", {27'd0, ex_dst}, 32'd3);

        drive(1'b1, 32'h8C220000, 32'h40, 32'd0);
        tick();
        drive(1'b1, 32'h00001820, 32'd0, 32'd0);
        #1;
        chk("lu0.stall", {31'd0, id_stall}, 32'd0);
        tick();
        chk("lu0.ctrl", {26'd0, ex_alu_ctrl}, 32'h03);
        chk("lu0.valid", {31'd0, ex_valid}, 32'd1);

        drive(1'b1, 32'hAC250008, 32'h100, 32'hDEAD);
        tick();
        chk("sw.mw", {31'd0, ex_mem_write}, 32'd1);
        chk("sw.rw", {31'd0, ex_reg_write}, 32'd0);
        chk("sw.a", ex_a, 32'h100);
        chk("sw.b", ex_b, 32'h8);
        chk("sw.st", ex_store_data, 32'hDEAD);
        ex_hold = 1'b1;
        drive(1'b1, 32'h00221821, 32'd1, 32'd2);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold.stall", {31'd0, id_stall}, 32'd1);
            tick();
            chk("hold.mw", {31'd0, ex_mem_write}, 32'd1);
            chk("hold.st", ex_store_data, 32'hDEAD);
            chk("hold.ctrl", {26'd0, ex_alu_ctrl}, 32'h01);
        end
        flush = 1'b1;
        #1;
        chk("flush.stall", {31'd0, id_stall}, 32'd0);
        tick();
        chk_bubble("flush");
        ex_hold = 1'b0;
        flush = 1'b0;

        drive(1'b1, 32'hFC000000, 32'd1, 32'd2);
        tick();
        chk("ill.flag", {31'd0, ex_illegal}, 32'd1);
        chk("ill.rw", {31'd0, ex_reg_write}, 32'd0);
        chk("ill.ctrl", {26'd0, ex_alu_ctrl}, 32'd0);
        chk("ill.valid", {31'd0, ex_valid}, 32'd1);

        drive(1'b1, 32'h10220004, 32'd6, 32'd6);
        tick();
        chk("beq.ctrl", {26'd0, ex_alu_ctrl}, 32'h02);
        chk("beq.br", {31'd0, ex_branch}, 32'd1);
        chk("beq.rw", {31'd0, ex_reg_write}, 32'd0);
        chk("beq.b", ex_b, 32'd6);

        drive(1'b0, 32'h00221821, 32'd1, 32'd2);
        tick();
        chk_bubble("novalid");

        drive(1'b1, 32'h8C220000, 32'h40, 32'd0);
        tick();
        drive(1'b1, 32'h00421820, 32'd1, 32'd1);
        #1;
        chk("rh.stall", {31'd0, id_stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rh.stall_rst", {31'd0, id_stall}, 32'd0);
        tick();
        chk_bubble("rh");
        chk("rh.stall_after", {31'd0, id_stall}, 32'd0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        chk_bubble("rh.idle");
        chk("rh.idle_stall", {31'd0, id_stall}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_alu_issue.md
Name: id_ex_alu_issue

Overview:
- Decodes the ID-stage MIPS instruction into the ALU operation code, shift amount, operands and memory/writeback controls, and registers them as the ID/EX pipeline register that drives the ALU.
- Detects load-use hazards and inserts one bubble per hazard.
- Honours downstream hold and branch flush.
- Sits between register-file read (ID) and the ALU (EX) in the 5-stage CPU.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_instr  in  32  instruction word
- id_rs_data  in  32  GPR[rs]
- id_rt_data  in  32  GPR[rt]
- ex_hold  in  1  EX/MEM cannot accept; freeze the register
- flush  in  1  branch/jump taken; kill the ID instruction
- id_stall  out  1  comb; IF/ID must hold this cycle
- ex_valid  out  1  registered; EX slot holds a real instruction
- ex_alu_ctrl  out  6  ALU operation code
- ex_sa  out  5  shift amount (instr[10:6])
- ex_a  out  32  ALU operand A (rs data)
- ex_b  out  32  ALU operand B (rt data or extended immediate)
- ex_store_data  out  32  rt data for sw
- ex_dst  out  5  destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each  controls
- ex_illegal  out  1  unsupported opcode/funct

Behaviour:
- **Reset:** all ex_* outputs are 0 (bubble). id_stall is 0 while rst is high.
- **Latency:** one cycle from ID inputs to ex_* outputs.
- **ALU codes:** addu 6'h01, subu 6'h02, add 6'h03, and 6'h04, or 6'h05, slt 6'h06, lui 6'h07, sll 6'h08. 6'h00 means no-op; the ALU returns 0 for it.
- **R-type (op 0)** by funct:
  - 20 add, 21 addu, 23 subu, 24 and, 25 or, 2A slt, 00 sll.
  - dst = rd; reg_write = 1; b = rt data.
  - sll uses sa.
  - Instruction 32'h0 is sll $0 (nop); it is legal and writes $0.
- **I-type** (dst = rt, reg_write = 1):
  - addiu 09: addu, sign-extended immediate.
  - ori 0D: or, zero-extended immediate.
  - lui 0F: lui, b = zero-extended immediate.
  - lw 23: addu, sign-extended immediate, mem_read = 1, mem_to_reg = 1.
- **sw 2B:** addu, sign-extended immediate, mem_write = 1, reg_write = 0, store_data = rt data.
- **beq 04:** subu, b = rt data, branch = 1, reg_write = 0.
- **Anything else:** illegal = 1, alu_ctrl = 0, all enables = 0, valid = 1.
- **Load-use hazard (comb):** all of the following hold:
  - ex_valid, ex_mem_read, ex_dst != 0, id_valid;
  - and either ex_dst == rs, or ex_dst == rt where the ID instruction reads rt (R-type, sw, beq).
- **id_stall** = !rst & !flush & (ex_hold | hazard).
- **Per-cycle update priority:**
  1. rst → bubble.
  2. flush → bubble, even with ex_hold or hazard active.
  3. ex_hold → all ex_* hold their values.
  4. hazard → bubble; the ID instruction is re-presented next cycle.
  5. !id_valid → bubble.
  6. Otherwise load the decoded instruction.
- **Bubble:** valid = 0; every enable, illegal, alu_ctrl and data field = 0.
- A hazard lasts exactly one cycle: after the bubble, ex_mem_read = 0, so the hazard clears.
- Reset mid-hold or mid-hazard: bubble on the next edge; no state survives.
- **Sign extension:** {{16{imm[15]}}, imm}. **Zero extension:** {16'h0, imm}.

Decomposition:
- The ALU op codes (6'h00–6'h08) and the MIPS opcode/funct constants are defined in the shared include header, which both this block and the ALU consume.
- Natural sub-module: `alu_issue_decode`. It is purely combinational (instr → alu_ctrl, sa, immediate select, dst select, enables, illegal, uses_rt) and is instantiated once inside the registered wrapper.

Test Plan:
- **R-type decode:** rst 2 cycles, then addu $3,$1,$2 (32'h00221821) with rs = 5, rt = 7 → next cycle ex_alu_ctrl = 01, a = 5, b = 7, dst = 3, reg_write = 1, valid = 1.
- **Immediate extension:**
  - addiu $4,$0,-1 (32'h2404FFFF) → ex_b = FFFFFFFF, alu_ctrl = 01.
  - ori $4,$0,0xFFFF (32'h3404FFFF) → ex_b = 0000FFFF, alu_ctrl = 05.
  - lui $4,0x1234 → alu_ctrl = 07, b = 00001234.
- **Load-use:** lw $2,0($1) followed by add $3,$2,$2 → id_stall = 1 for one cycle, bubble (valid = 0), then add issues with alu_ctrl = 03.
  - lw then add using $0 → no stall.
- **Hold vs flush:**
  - Issue sw, then ex_hold = 1 for 3 cycles → outputs frozen, id_stall = 1.
  - Raise flush during hold → next cycle bubble, id_stall = 0.
- **Illegal and beq:**
  - Opcode 6'h3F → ex_illegal = 1, reg_write = 0, alu_ctrl = 0.
  - beq $1,$2 → alu_ctrl = 02, branch = 1, reg_write = 0.
- **Reset mid-hazard:** assert rst during the load-use stall cycle → all ex_* = 0 and id_stall = 0 in the same cycle and after the edge.
